// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and default parameters for the regfile write-port arbiter.
package wb_port_arbiter_pkg;

  localparam int XLEN_DEF         = 64;
  localparam int AW_DEF           = 5;
  localparam int MDU_FIFO_DEPTH   = 2;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_MDU  = 2'd2
  } gnt_src_e;

  // Width of a counter that must hold values 0..limit inclusive.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/wb_mdu_fifo.sv
// Circular buffer of MDU results {valid, rd, data}; entries can be killed by
// destination address without disturbing order or occupancy.
module wb_mdu_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = MDU_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [AW-1:0]            push_rd,
  input  logic [XLEN-1:0]          push_data,
  input  logic                     pop,
  input  logic                     kill_en,
  input  logic [AW-1:0]            kill_rd,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_valid,
  output logic [AW-1:0]            head_rd,
  output logic [XLEN-1:0]          head_data,
  output logic                     any_valid
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] valid_reg, valid_next;
  logic [AW-1:0]    rd_mem   [DEPTH];
  logic [XLEN-1:0]  data_mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]      count_reg;
  logic             do_push, do_pop;

  assign do_push = push && (count_reg < (PW+1)'(DEPTH));
  assign do_pop  = pop && (count_reg != '0);

  // The slot being written is never occupied, so a same-edge kill cannot
  // reach the incoming entry; push therefore takes priority per slot.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      always_comb begin
        valid_next[gi] = valid_reg[gi];
        if (kill_en && (rd_mem[gi] == kill_rd))
          valid_next[gi] = 1'b0;
        if (do_pop && (rd_ptr_reg == PW'(gi)))
          valid_next[gi] = 1'b0;
        if (do_push && (wr_ptr_reg == PW'(gi)))
          valid_next[gi] = 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      valid_reg <= valid_next;
      if (do_push)
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (PW+1)'(1);
        2'b01:   count_reg <= count_reg - (PW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Payload storage carries no reset; validity lives only in valid_reg.
  always_ff @(posedge clk) begin
    if (do_push) begin
      rd_mem[wr_ptr_reg]   <= push_rd;
      data_mem[wr_ptr_reg] <= push_data;
    end
  end

  assign count      = count_reg;
  assign head_valid = (count_reg != '0) && valid_reg[rd_ptr_reg];
  assign head_rd    = rd_mem[rd_ptr_reg];
  assign head_data  = data_mem[rd_ptr_reg];
  assign any_valid  = |valid_reg;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between pipeline writeback and buffered MDU
// results; pipeline has priority, a one-cycle stall prevents MDU starvation.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int AW           = AW_DEF,
  parameter int DEPTH        = MDU_FIFO_DEPTH,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_wreg,
  input  logic [AW-1:0]   wb_wd,
  input  logic [XLEN-1:0] wb_wdata,
  input  logic            mdu_valid,
  output logic            mdu_ready,
  input  logic [AW-1:0]   mdu_wd,
  input  logic [XLEN-1:0] mdu_wdata,
  output logic            stall_req,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            mdu_pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT    = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(STARVE_LIMIT - 1);

  logic [PW:0]     fifo_count;
  logic            head_valid;
  logic [AW-1:0]   head_rd;
  logic [XLEN-1:0] head_data;
  logic            any_valid;
  logic            pipe_req, push, pop;
  gnt_src_e        gnt;
  logic [CW-1:0]   starve_cnt_reg;
  logic            stall_req_reg;

  assign pipe_req  = wb_wreg && (wb_wd != '0);
  assign mdu_ready = (fifo_count < (PW+1)'(DEPTH));
  // Writes to r0 are accepted from the MDU but never buffered.
  assign push      = mdu_valid && mdu_ready && (mdu_wd != '0);
  // A killed head is drained silently so it never blocks younger results.
  assign pop       = (gnt == GNT_MDU) || ((fifo_count != '0) && !head_valid);

  wb_mdu_fifo #(
    .XLEN  (XLEN),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_rd    (mdu_wd),
    .push_data  (mdu_wdata),
    .pop        (pop),
    .kill_en    (gnt == GNT_PIPE),
    .kill_rd    (wb_wd),
    .count      (fifo_count),
    .head_valid (head_valid),
    .head_rd    (head_rd),
    .head_data  (head_data),
    .any_valid  (any_valid)
  );

  // During the stall cycle mem_wb is frozen and will retry, so its request
  // is ignored even when the head has been killed in the meantime.
  always_comb begin
    gnt = GNT_NONE;
    if (stall_req_reg) begin
      if (head_valid)
        gnt = GNT_MDU;
    end else if (pipe_req) begin
      gnt = GNT_PIPE;
    end else if (head_valid) begin
      gnt = GNT_MDU;
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    case (gnt)
      GNT_PIPE: begin
        rf_we    = 1'b1;
        rf_waddr = wb_wd;
        rf_wdata = wb_wdata;
      end
      GNT_MDU: begin
        rf_we    = 1'b1;
        rf_waddr = head_rd;
        rf_wdata = head_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_reg <= '0;
      stall_req_reg  <= 1'b0;
    end else if (stall_req_reg) begin
      starve_cnt_reg <= '0;
      stall_req_reg  <= 1'b0;
    end else if (!head_valid || (gnt == GNT_MDU)) begin
      starve_cnt_reg <= '0;
    end else begin
      if (starve_cnt_reg != LIMIT)
        starve_cnt_reg <= starve_cnt_reg + CW'(1);
      if (starve_cnt_reg == LIMIT_M1)
        stall_req_reg <= 1'b1;
    end
  end

  assign stall_req   = stall_req_reg;
  assign mdu_pending = any_valid;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: writes are scoreboarded in order, and
// stall/ready/pending timing is checked cycle by cycle.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wb_wreg;
  logic [4:0]  wb_wd;
  logic [63:0] wb_wdata;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_wd;
  logic [63:0] mdu_wdata;
  logic        stall_req;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        mdu_pending;

  typedef struct packed {
    logic [4:0]  a;
    logic [63:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [63:0] rf_model [32];
  int          pass_cnt  = 0;
  int          total_cnt = 0;

  wb_port_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_wreg     (wb_wreg),
    .wb_wd       (wb_wd),
    .wb_wdata    (wb_wdata),
    .mdu_valid   (mdu_valid),
    .mdu_ready   (mdu_ready),
    .mdu_wd      (mdu_wd),
    .mdu_wdata   (mdu_wdata),
    .stall_req   (stall_req),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .mdu_pending (mdu_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic pipe(input logic en, input logic [4:0] rd, input logic [63:0] d);
    wb_wreg  = en;
    wb_wd    = rd;
    wb_wdata = d;
  endtask

  task automatic mdu(input logic en, input logic [4:0] rd, input logic [63:0] d);
    mdu_valid = en;
    mdu_wd    = rd;
    mdu_wdata = d;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [63:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Sample at the falling edge and match any write against the scoreboard.
  task automatic settle();
    wr_t e;
    @(negedge clk);
    if (rf_we) begin
      rf_model[rf_waddr] = rf_wdata;
      $display("%0t wr rd=%0d data=0x%0h", $time, rf_waddr, rf_wdata);
      if (exp_q.size() == 0) begin
        total_cnt++;
        $error("FAIL sb_extra_write: observed rd=%0d data=0x%0h expected no write",
               rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("sb_addr", 64'(rf_waddr), 64'(e.a));
        chk("sb_data", rf_wdata, e.d);
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    settle();
    advance();
  endtask

  initial begin
    rst_n = 1'b0;
    pipe(0, 0, 0);
    mdu(0, 0, 0);
    for (int i = 0; i < 32; i++) rf_model[i] = '0;
    #1;
    chk("rst_stall", 64'(stall_req), 64'd0);
    chk("rst_pending", 64'(mdu_pending), 64'd0);
    chk("rst_ready", 64'(mdu_ready), 64'd1);
    chk("rst_we_idle", 64'(rf_we), 64'd0);
    pipe(1, 2, 64'hAA);
    #1;
    chk("rst_follow_we", 64'(rf_we), 64'd1);
    chk("rst_follow_addr", 64'(rf_waddr), 64'd2);
    chk("rst_follow_data", rf_wdata, 64'hAA);
    pipe(0, 0, 0);
    advance();
    advance();
    rst_n = 1'b1;
    advance();

    // Single MDU beat on an idle pipeline.
    mdu(1, 5, 64'h1234);
    #1;
    chk("t1_ready", 64'(mdu_ready), 64'd1);
    chk("t1_we_before", 64'(rf_we), 64'd0);
    expect_wr(5, 64'h1234);
    cyc();
    mdu(0, 0, 0);
    #1;
    chk("t1_we", 64'(rf_we), 64'd1);
    chk("t1_pending", 64'(mdu_pending), 64'd1);
    cyc();
    #1;
    chk("t1_pending_drop", 64'(mdu_pending), 64'd0);
    chk("t1_we_after", 64'(rf_we), 64'd0);
    cyc();
    chk("t1_drain", 64'(exp_q.size()), 64'd0);

    // Starvation: continuous pipeline writes to r3 versus one MDU beat to r7.
    pipe(1, 3, 64'hD0);
    mdu(1, 7, 64'h77);
    #1;
    chk("t2_ready", 64'(mdu_ready), 64'd1);
    expect_wr(3, 64'hD0);
    cyc();
    mdu(0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      pipe(1, 3, 64'hD0 + 64'(k));
      #1;
      chk("t2_stall_low", 64'(stall_req), 64'd0);
      chk("t2_pipe_addr", 64'(rf_waddr), 64'd3);
      expect_wr(3, 64'hD0 + 64'(k));
      cyc();
    end
    #1;
    chk("t2_stall_high", 64'(stall_req), 64'd1);
    chk("t2_stall_addr", 64'(rf_waddr), 64'd7);
    expect_wr(7, 64'h77);
    cyc();
    #1;
    chk("t2_stall_clear", 64'(stall_req), 64'd0);
    chk("t2_retry_addr", 64'(rf_waddr), 64'd3);
    expect_wr(3, 64'hD4);
    cyc();
    pipe(0, 0, 0);
    cyc();
    chk("t2_drain", 64'(exp_q.size()), 64'd0);

    // Full FIFO backpressure and ordering.
    pipe(1, 10, 64'hA0);
    mdu(1, 11, 64'hB1);
    #1;
    chk("t3_ready0", 64'(mdu_ready), 64'd1);
    expect_wr(10, 64'hA0);
    cyc();
    pipe(1, 10, 64'hA1);
    mdu(1, 12, 64'hB2);
    #1;
    chk("t3_ready1", 64'(mdu_ready), 64'd1);
    expect_wr(10, 64'hA1);
    cyc();
    pipe(1, 10, 64'hA2);
    mdu(1, 13, 64'hB3);
    #1;
    chk("t3_full", 64'(mdu_ready), 64'd0);
    expect_wr(10, 64'hA2);
    cyc();
    pipe(0, 0, 0);
    #1;
    chk("t3_full_on_pop", 64'(mdu_ready), 64'd0);
    chk("t3_no_stall", 64'(stall_req), 64'd0);
    expect_wr(11, 64'hB1);
    cyc();
    #1;
    chk("t3_ready_again", 64'(mdu_ready), 64'd1);
    expect_wr(12, 64'hB2);
    cyc();
    mdu(0, 0, 0);
    expect_wr(13, 64'hB3);
    cyc();
    #1;
    chk("t3_pending_end", 64'(mdu_pending), 64'd0);
    cyc();
    chk("t3_drain", 64'(exp_q.size()), 64'd0);

    // WAW kill: buffered r9 overwritten by a younger pipeline write.
    pipe(1, 20, 64'hC0);
    mdu(1, 9, 64'h999);
    expect_wr(20, 64'hC0);
    cyc();
    mdu(0, 0, 0);
    pipe(1, 9, 64'h5A5A);
    #1;
    chk("t4_pending_live", 64'(mdu_pending), 64'd1);
    expect_wr(9, 64'h5A5A);
    cyc();
    pipe(0, 0, 0);
    #1;
    chk("t4_killed_no_we", 64'(rf_we), 64'd0);
    chk("t4_killed_pending", 64'(mdu_pending), 64'd0);
    cyc();
    #1;
    chk("t4_idle_we", 64'(rf_we), 64'd0);
    chk("t4_ready", 64'(mdu_ready), 64'd1);
    cyc();
    chk("t4_rf_r9", rf_model[9], 64'h5A5A);
    chk("t4_drain", 64'(exp_q.size()), 64'd0);

    // Kill and enqueue in the same cycle: the new r14 entry survives.
    pipe(1, 21, 64'hC1);
    mdu(1, 14, 64'hE1);
    expect_wr(21, 64'hC1);
    cyc();
    pipe(1, 14, 64'hF14);
    mdu(1, 14, 64'hE2);
    expect_wr(14, 64'hF14);
    cyc();
    pipe(0, 0, 0);
    mdu(0, 0, 0);
    #1;
    chk("t4b_dead_head_we", 64'(rf_we), 64'd0);
    chk("t4b_pending", 64'(mdu_pending), 64'd1);
    cyc();
    expect_wr(14, 64'hE2);
    cyc();
    cyc();
    chk("t4b_rf_r14", rf_model[14], 64'hE2);
    chk("t4b_drain", 64'(exp_q.size()), 64'd0);

    // r0 on both sources is dropped.
    pipe(1, 0, 64'h111);
    mdu(1, 0, 64'h222);
    #1;
    chk("t5_we", 64'(rf_we), 64'd0);
    chk("t5_ready", 64'(mdu_ready), 64'd1);
    cyc();
    pipe(0, 0, 0);
    mdu(0, 0, 0);
    #1;
    chk("t5_pending", 64'(mdu_pending), 64'd0);
    chk("t5_we_after", 64'(rf_we), 64'd0);
    cyc();

    // Asynchronous reset with a full FIFO and a stall pending.
    pipe(1, 3, 64'h300);
    mdu(1, 15, 64'hF15);
    expect_wr(3, 64'h300);
    cyc();
    mdu(1, 16, 64'hF16);
    for (int k = 1; k <= 4; k++) begin
      pipe(1, 3, 64'h300 + 64'(k));
      expect_wr(3, 64'h300 + 64'(k));
      cyc();
      mdu(0, 0, 0);
    end
    #1;
    chk("t6_stall_pre", 64'(stall_req), 64'd1);
    chk("t6_pending_pre", 64'(mdu_pending), 64'd1);
    chk("t6_full_pre", 64'(mdu_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("t6_stall_rst", 64'(stall_req), 64'd0);
    chk("t6_pending_rst", 64'(mdu_pending), 64'd0);
    chk("t6_ready_rst", 64'(mdu_ready), 64'd1);
    pipe(0, 0, 0);
    advance();
    rst_n = 1'b1;
    #1;
    chk("t6_ready_rel", 64'(mdu_ready), 64'd1);
    chk("t6_we_rel", 64'(rf_we), 64'd0);
    cyc();
    cyc();
    chk("t6_drain", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback (mem_wb outputs) and the multi-cycle multiply/divide unit (MDU) result stream.
- Buffers MDU results in a small FIFO and gives the pipeline priority.
- Prevents MDU starvation by requesting a one-cycle pipeline stall, and kills buffered MDU results overwritten by a younger pipeline write (WAW).
- Sits between mem_wb, the MDU and the regfile; stall_req feeds the pipeline control.

Parameters:
- XLEN, 64, data width (matches `RegBus).
- AW, 5, register address width (matches `RegAddrBus).
- DEPTH, 2, MDU result FIFO entries (power of 2, ≥2).
- STARVE_LIMIT, 4, consecutive lost arbitration cycles before stall_req is raised (≥1).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- wb_wreg  in  1  pipeline writeback enable (from mem_wb)
- wb_wd  in  AW  pipeline destination register
- wb_wdata  in  XLEN  pipeline writeback data
- mdu_valid  in  1  MDU result valid
- mdu_ready  out  1  arbiter can accept MDU result
- mdu_wd  in  AW  MDU destination register
- mdu_wdata  in  XLEN  MDU result data
- stall_req  out  1  registered request to freeze mem_wb and earlier stages for one cycle
- rf_we  out  1  regfile write enable
- rf_waddr  out  AW  regfile write address
- rf_wdata  out  XLEN  regfile write data
- mdu_pending  out  1  FIFO holds at least one live entry

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, all entry valid bits clear, starve counter 0, stall_req 0. The remaining outputs are combinational and, with an empty FIFO and no stall, follow the pipeline inputs.
- Enqueue:
  - mdu_ready = (count < DEPTH). It does not depend on a same-cycle pop.
  - An MDU beat is accepted on mdu_valid && mdu_ready.
  - A beat with mdu_wd == 0 is accepted but not stored.
- pipe_req = wb_wreg && (wb_wd != 0).
- Grant priority, evaluated each cycle, combinational:
  1. If stall_req == 1 and the head is live, grant the head. The pipeline input is ignored this cycle; it is held by the stall and retried next cycle.
  2. Else if pipe_req, grant the pipeline.
  3. Else if the head is live, grant the head.
  4. Else no grant.
- Write port outputs:
  - rf_we = 1 only on a grant; rf_waddr/rf_wdata come from the granted source.
  - When rf_we = 0, rf_waddr and rf_wdata are 0.
  - The regfile samples on the next rising edge; zero added latency.
- Pop: the head pops on the edge that ends a head-grant cycle.
- WAW kill:
  - On a pipeline grant, every FIFO entry whose rd equals wb_wd has its valid bit cleared on that edge.
  - A killed (invalid) head pops on the next edge without using the write port and without a grant.
  - A killed head is not "live".
- Simultaneous events:
  - Enqueue and pop in one cycle: count is unchanged and order is preserved.
  - Kill and enqueue in one cycle: the kill applies only to entries present before the edge. The newly enqueued entry survives even if its rd matches.
- Starve counter:
  - Increments when the head is live and not granted.
  - Clears when the head is granted or the FIFO has no live head.
  - Saturates at STARVE_LIMIT.
  - When the counter == STARVE_LIMIT-1 and the head loses again, stall_req = 1 on the next cycle.
- stall_req:
  - Stays high for exactly one cycle and then clears, together with the counter.
  - If the head was killed before the stall cycle, stall_req still clears after one cycle and no write occurs.
- mdu_pending = OR of all entry valid bits.
- Reset mid-operation drops all buffered results. There is no replay; the MDU is reset by the same rst_n.

Decomposition:
- Shared defines.v supplies `RegBus, `RegAddrBus, `NOPRegAddr, `ZeroWord, `WriteEnable/`WriteDisable. Add `MduFifoDepth and `StarveLimit defaults there.
- One sub-module, wb_mdu_fifo: DEPTH-entry circular FIFO holding {valid, rd, data}, with push, pop, a kill-by-address port, count and head outputs.
- Arbitration, the starve counter and stall_req stay in wb_port_arbiter.

Test Plan:
- Idle pipeline, MDU beat rd=5 data=0x1234 → accepted (mdu_ready=1). Next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; mdu_pending drops after that edge.
- Continuous pipe_req (rd=3) and one MDU beat rd=7 → pipeline granted 4 cycles, stall_req=1 on cycle 5. That cycle rf_waddr=7 and wb ignored; stall_req=0 on cycle 6, and rd=3 is granted again.
- Two MDU beats with no pops → FIFO full, mdu_ready=0. A third mdu_valid is held until the first pop; ordering of data out matches input order.
- MDU rd=9 buffered while the pipeline writes rd=9 → entry killed; it pops without any rf_we for rd=9 from the MDU; the regfile ends with the pipeline value.
- MDU beat with mdu_wd=0, and pipeline wb_wreg=1 wb_wd=0 → rf_we stays 0, nothing enqueued, mdu_pending=0.
- rst_n pulled low mid-cycle with 2 entries and stall pending → stall_req, mdu_pending and count go to 0 immediately without a clock edge; after release, mdu_ready=1.
